// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit for the EX stage; owns the HI/LO registers.
// Latency: N+1 cycles from the start edge to done (1 cycle for divide-by-zero).
// Backpressure: busy stalls the pipeline; start while busy is ignored, abort cancels.
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-low reset
//   start, op, a, b operation request (op: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU)
//   abort           cancel the in-flight operation; HI/LO keep their old values
//   hi_we, lo_we    MTHI/MTLO write of wdata, honoured only in IDLE with start=0
//   busy            registered, high while state != IDLE
//   done, div_zero  one-cycle completion pulses; HI/LO already updated
//   hi_out, lo_out  HI/LO architectural registers
module muldiv_unit #(
  parameter int SIZE_DATA = 32,
  parameter int S_OP_MD   = 2,
  parameter int CNT_W     = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [S_OP_MD-1:0]   op,
  input  logic [SIZE_DATA-1:0] a,
  input  logic [SIZE_DATA-1:0] b,
  input  logic                 abort,
  input  logic                 hi_we,
  input  logic                 lo_we,
  input  logic [SIZE_DATA-1:0] wdata,
  output logic                 busy,
  output logic                 done,
  output logic                 div_zero,
  output logic [SIZE_DATA-1:0] hi_out,
  output logic [SIZE_DATA-1:0] lo_out
);

  localparam int N = SIZE_DATA;
  localparam logic [N-1:0]     ONE_N  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [2*N-1:0]   ONE_2N = {{(2*N-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(N-1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state, state_next;

  // Working registers. acc holds {partial product high, multiplier} during a
  // multiply and {partial remainder, dividend/quotient} during a divide.
  logic [2*N-1:0]   acc;
  logic [N-1:0]     opb;        // |multiplicand| or |divisor|
  logic [CNT_W-1:0] cnt;
  logic             is_div;
  logic             neg_q;      // negate product / quotient in FIX
  logic             neg_r;      // negate remainder in FIX
  logic             dz;         // divide-by-zero pending

  // Request decode
  logic           op_valid;
  logic           req_div;
  logic           req_signed;
  logic           accept;
  logic [N-1:0]   abs_a;
  logic [N-1:0]   abs_b;

  // Op encodings wider than two bits are only valid when the extra bits are zero.
  if (S_OP_MD > 2) begin : g_opchk
    assign op_valid = ~|op[S_OP_MD-1:2];
  end else begin : g_opall
    assign op_valid = 1'b1;
  end

  assign req_div    = op[1];
  assign req_signed = ~op[0];
  assign accept     = (state == IDLE) && start && op_valid && !abort;

  // Magnitudes are mod 2^N, so the most negative value maps to itself.
  assign abs_a = (req_signed && a[N-1]) ? (~a + ONE_N) : a;
  assign abs_b = (req_signed && b[N-1]) ? (~b + ONE_N) : b;

  // Multiply step: add the multiplicand to the high half when the current
  // multiplier bit is set, then shift the whole accumulator right by one.
  logic [N:0]     mul_sum;
  logic [2*N-1:0] mul_next;
  assign mul_sum  = {1'b0, acc[2*N-1:N]} + {1'b0, opb};
  assign mul_next = acc[0] ? {mul_sum, acc[N-1:1]}
                           : {1'b0, acc[2*N-1:N], acc[N-1:1]};

  // Restoring divide step: shift the next dividend bit into the remainder and
  // subtract the divisor if it fits. The shifted remainder is N+1 bits but the
  // difference, when taken, is always below the divisor and fits in N bits.
  logic [N:0]     shifted;
  logic           qbit;
  logic [N-1:0]   rem_sub;
  logic [N-1:0]   rem_next;
  logic [2*N-1:0] div_next;
  assign shifted  = {acc[2*N-1:N], acc[N-1]};
  assign qbit     = (shifted >= {1'b0, opb});
  assign rem_sub  = shifted[N-1:0] - opb;
  assign rem_next = qbit ? rem_sub : shifted[N-1:0];
  assign div_next = {rem_next, acc[N-2:0], qbit};

  // Sign correction applied in FIX.
  logic [2*N-1:0] prod_fix;
  logic [N-1:0]   quot_fix;
  logic [N-1:0]   rem_fix;
  assign prod_fix = neg_q ? (~acc + ONE_2N) : acc;
  assign quot_fix = neg_q ? (~acc[N-1:0] + ONE_N) : acc[N-1:0];
  assign rem_fix  = neg_r ? (~acc[2*N-1:N] + ONE_N) : acc[2*N-1:N];

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = (req_div && (b == '0)) ? FIX : CALC;
        end
      end
      CALC: begin
        if (abort) begin
          state_next = IDLE;
        end else if (cnt == LAST) begin
          state_next = FIX;
        end
      end
      FIX: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register and datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi_out   <= '0;
      lo_out   <= '0;
      acc      <= '0;
      opb      <= '0;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dz       <= 1'b0;
    end else begin
      state    <= state_next;
      busy     <= (state_next != IDLE);
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            is_div <= req_div;
            cnt    <= '0;
            neg_q  <= req_signed && (a[N-1] ^ b[N-1]);
            neg_r  <= req_signed && a[N-1];
            opb    <= abs_b;
            if (req_div && (b == '0)) begin
              // Keep the raw dividend pattern; it becomes HI.
              acc <= {{N{1'b0}}, a};
              dz  <= 1'b1;
            end else begin
              acc <= {{N{1'b0}}, abs_a};
              dz  <= 1'b0;
            end
          end else if (!start) begin
            if (hi_we) hi_out <= wdata;
            if (lo_we) lo_out <= wdata;
          end
        end
        CALC: begin
          if (!abort) begin
            acc <= is_div ? div_next : mul_next;
            cnt <= cnt + ONE_C;
          end
        end
        FIX: begin
          if (!abort) begin
            done <= 1'b1;
            if (dz) begin
              lo_out   <= '1;
              hi_out   <= acc[N-1:0];
              div_zero <= 1'b1;
            end else if (is_div) begin
              lo_out <= quot_fix;
              hi_out <= rem_fix;
            end else begin
              hi_out <= prod_fix[2*N-1:N];
              lo_out <= prod_fix[N-1:0];
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
